// File: rtl/unsigned_pipe_mac.sv
// -----------------------------------------------------------------------------
// unsigned_pipe_mac
//
// Purpose:
//   Pipelined unsigned multiply-accumulate leaf: out = i_a * i_b + i_c.
//   Free-running, with no handshake. One operand set is accepted and one
//   result is produced on every clock.
//
//   Default build: two register stages, so latency is 2 rising edges.
//     Stage 1: product and delayed addend.
//     Stage 2: sum, registered onto out.
//
//   Optional build macro: UNSIGNED_PIPE_INREG_EN
//     When defined, an input register stage captures i_a/i_b/i_c ahead of
//     Stage 1. Latency becomes 3 rising edges. Throughput and result are
//     unchanged.
//
// Parameters:
//   W_IN   operand width (i_a, i_b, i_c)
//   W_OUT  result width, must equal 2*W_IN. The maximum result is
//          2^(2*W_IN) - 2^W_IN, so the sum never carries out.
//
// Ports:
//   clk    input         rising-edge clock
//   rst_n  input         asynchronous active-low reset; clears all state
//   i_a    input  W_IN   unsigned multiplicand
//   i_b    input  W_IN   unsigned multiplier
//   i_c    input  W_IN   unsigned addend
//   out    output W_OUT  registered result
// -----------------------------------------------------------------------------
module unsigned_pipe_mac #(
    parameter int W_IN  = 4,
    parameter int W_OUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_IN-1:0]  i_a,
    input  logic [W_IN-1:0]  i_b,
    input  logic [W_IN-1:0]  i_c,
    output logic [W_OUT-1:0] out
);

    // Zero-extend an operand to the result width before any arithmetic.
    function automatic logic [W_OUT-1:0] zext(input logic [W_IN-1:0] v);
        zext = W_OUT'(v);
    endfunction

    // Operands as seen by Stage 1.
    logic [W_IN-1:0] a_s;
    logic [W_IN-1:0] b_s;
    logic [W_IN-1:0] c_s;

`ifdef UNSIGNED_PIPE_INREG_EN
    // ---- Input register stage ----
    logic [W_IN-1:0] a_in_q;
    logic [W_IN-1:0] b_in_q;
    logic [W_IN-1:0] c_in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_in_q <= '0;
            b_in_q <= '0;
            c_in_q <= '0;
        end else begin
            a_in_q <= i_a;
            b_in_q <= i_b;
            c_in_q <= i_c;
        end
    end

    assign a_s = a_in_q;
    assign b_s = b_in_q;
    assign c_s = c_in_q;
`else
    assign a_s = i_a;
    assign b_s = i_b;
    assign c_s = i_c;
`endif

    // ---- Stage 1: product, addend delayed alongside it ----
    logic [W_OUT-1:0] prod_d;
    logic [W_OUT-1:0] prod_q;
    logic [W_IN-1:0]  c_q;

    always_comb begin
        prod_d = zext(a_s) * zext(b_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            c_q    <= '0;
        end else begin
            prod_q <= prod_d;
            c_q    <= c_s;
        end
    end

    // ---- Stage 2: accumulate and register the result ----
    logic [W_OUT-1:0] out_d;
    logic [W_OUT-1:0] out_q;

    always_comb begin
        out_d = prod_q + zext(c_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_unsigned_pipe_mac.sv
// -----------------------------------------------------------------------------
// tb_unsigned_pipe_mac
//
// Scoreboard bench for unsigned_pipe_mac. The driver issues one operand set
// per falling edge. For each set it pushes the expected value a*b+c, together
// with the rising-edge count at which that value must appear on out.
//
// A separate monitor samples out 5 ns after every rising edge:
//   - In reset, out must be 0.
//   - If an entry is due on this edge, it is popped and compared with out.
//   - Otherwise the pipeline still holds cleared state, so out must be 0.
//
// Define UNSIGNED_PIPE_INREG_EN to check the 3-edge latency variant.
// -----------------------------------------------------------------------------
module tb_unsigned_pipe_mac;

    localparam int W_IN  = 4;
    localparam int W_OUT = 8;
`ifdef UNSIGNED_PIPE_INREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W_IN-1:0]  i_a;
    logic [W_IN-1:0]  i_b;
    logic [W_IN-1:0]  i_c;
    logic [W_OUT-1:0] out;

    unsigned_pipe_mac #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_a   (i_a),
        .i_b   (i_b),
        .i_c   (i_c),
        .out   (out)
    );

    // 50 ns period: rising edges at 25, 75, 125, ...
    always #25 clk = ~clk;

    typedef struct {
        int due;
        int exp;
        int a;
        int b;
        int c;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done     = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: out=0x%02h required=0x%02h (edge %0d, t=%0t)",
                     name, got, req, edge_cnt, $time);
        end
    endtask

    // Call right after a falling edge. The next rising edge captures the
    // operands, and the result is visible after LAT rising edges in total.
    task automatic issue(input int a, input int b, input int c);
        exp_t e;
        i_a = W_IN'(a);
        i_b = W_IN'(b);
        i_c = W_IN'(c);
        e.due = edge_cnt + LAT;
        e.exp = a * b + c;
        e.a   = a;
        e.b   = b;
        e.c   = c;
        sb.push_back(e);
    endtask

    task automatic step(input int a, input int b, input int c);
        @(negedge clk);
        issue(a, b, c);
    endtask

    // Monitor
    always begin
        @(posedge clk);
        #5;
        if (!done) begin
            if (!rst_n) begin
                check("in_reset", int'(out), 0);
            end else if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("result a=%0d b=%0d c=%0d", e.a, e.b, e.c),
                      int'(out), e.exp);
            end else if (sb.size() > 0 && sb[0].due < edge_cnt) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missed_result a=%0d b=%0d c=%0d: out=0x%02h required=0x%02h at edge %0d",
                         e.a, e.b, e.c, out, e.exp, e.due);
            end else begin
                check("idle_after_reset", int'(out), 0);
            end
        end
    end

    initial begin
        // Reset held for 75 ns with zero inputs, then non-zero inputs under reset.
        rst_n = 1'b0;
        i_a   = '0;
        i_b   = '0;
        i_c   = '0;
        #1;
        check("reset_t0", int'(out), 0);
        #79;
        i_a = 4'd5;
        i_b = 4'd5;
        i_c = 4'd5;
        #1;
        check("reset_inputs_5", int'(out), 0);

        // Release on a falling edge, then issue the basic set and the
        // back-to-back stream immediately.
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 2, 3);
        step(3, 1, 4);
        step(0, 0, 0);

        // Extremes
        step(15, 15, 15);
        step(15, 15, 0);
        step(0, 0, 15);
        step(0, 15, 15);
        step(0, 0, 0);

        // Reset mid-stream: (2,3,1) reaches out (0x07) as (4,4,4) is
        // captured (0x14 in flight). Reset must clear both.
        step(2, 3, 1);
        step(4, 4, 4);
        @(posedge clk);
        #10;
        rst_n = 1'b0;
        i_a   = '0;
        i_b   = '0;
        i_c   = '0;
        sb.delete();
        #1;
        check("mid_reset_immediate", int'(out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 0, 0);
        repeat (5) step(0, 0, 0);

        // Random stream
        for (int i = 0; i < 1000; i++) begin
            step(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                 int'($urandom_range(15, 0)));
        end

        // Drain with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(posedge clk);
            #6;
        end
        done = 1'b1;
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unsigned_pipe_mac.md
Name: unsigned_pipe_mac

Overview:
- Two-stage pipelined unsigned arithmetic block that computes out = i_a * i_b + i_c.
- Free-running datapath with no handshake: one new operand set is accepted every clock and one result is produced every clock.
- Used as a small arithmetic leaf inside datapath pipelines, and as the reference pipelining example for the team's arithmetic blocks.

Parameters:
- W_IN, 4, bit width of each unsigned operand i_a, i_b, i_c.
- W_OUT, 8, result width; must equal 2*W_IN.
  - Max result (2^W_IN-1)^2 + (2^W_IN-1) = 2^(2*W_IN) - 2^W_IN, so the result never overflows.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- i_a  input  W_IN  unsigned multiplicand.
- i_b  input  W_IN  unsigned multiplier.
- i_c  input  W_IN  unsigned addend.
- out  output  W_OUT  registered result of i_a*i_b + i_c.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all pipeline registers and out are 0, independent of clk.
  - Reset deassertion is synchronized by the system. The first capture occurs on the first rising edge with rst_n=1.
- All arithmetic is unsigned and zero-extended to W_OUT before use. There are no signed interpretations and no saturation.
- Stage 1 (rising edge N):
  - prod_r <= i_a * i_b (W_OUT bits).
  - c_r <= i_c (W_IN bits, delayed to stay aligned with prod_r).
- Stage 2 (rising edge N+1):
  - out <= prod_r + zero_extend(c_r) (W_OUT bits, no carry out possible).
- Latency and throughput:
  - Operands sampled at edge N appear on out right after edge N+1: latency is 2 rising edges.
  - Throughput is 1 result per cycle. Back-to-back operand sets never interfere.
- Inputs are sampled only at rising edges. Changes between edges have no effect.
- out is driven directly from a flop: no combinational path from inputs to out.
- Reset mid-operation:
  - All in-flight results are discarded; out = 0 immediately.
  - After release, out stays 0 until the first post-reset operands have traversed both stages.
  - Any output that depends on pre-reset stage contents is 0, because those registers were cleared.
- Boundary cases:
  - All-zero inputs give 0.
  - All-ones inputs (15,15,15) give 240 (0xF0), the maximum. No wrap is possible at the default widths.
- No enable or stall input: the pipeline advances every cycle.

Optional Feature:
- Macro: UNSIGNED_PIPE_INREG_EN
- Defined:
  - An input register stage captures i_a, i_b, i_c before Stage 1. It is reset to 0 asynchronously like all other state.
  - Latency becomes 3 rising edges; throughput stays 1 per cycle.
  - Arithmetic result is unchanged.
- Undefined:
  - The 2-stage pipeline described above, latency 2.

Test Plan:
- Reset check: hold rst_n=0 for 75 ns with 50 ns clk period, inputs = 0 -> out = 0 throughout. Then drive inputs 5,5,5 with rst_n still 0 -> out remains 0.
- Basic: after reset release, apply a=1, b=2, c=3 for one cycle -> out = 0x05 exactly 2 edges after capture.
- Back-to-back stream:
  - Apply (1,2,3), then (3,1,4), then (0,0,0) on consecutive cycles.
  - Expected out on consecutive cycles: 0x05, then 0x07, then 0x00.
- Extremes: (15,15,15) -> 0xF0; (15,15,0) -> 0xE1; (0,0,15) -> 0x0F; (0,15,15) -> 0x0F.
- Reset mid-stream: stream (2,3,1), (4,4,4); assert rst_n between edges while both are in flight -> out = 0 immediately. After release with inputs held at 0 -> out stays 0, with no stale 0x07 or 0x14.
- Random: 1000 random operand triples compared against a 2-cycle-delayed golden model a*b+c. With UNSIGNED_PIPE_INREG_EN defined, the same check uses a 3-cycle delay.
